// File: rtl/sha256_msg_schedule_if.sv
// Handshake bundle for the SHA-256 message-schedule expander: a word-load
// channel in, a schedule-word channel out, plus a busy flag.
interface sha256_msg_schedule_if #(
    parameter int WORD_W = 32,
    parameter int IDX_W  = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              w_valid;
    logic              w_ready;
    logic [WORD_W-1:0] w_word;
    logic [IDX_W-1:0]  w_index;
    logic              w_last;
    logic              busy;

    // Producer of message words / consumer of schedule words.
    modport master (
        output in_valid, in_word, w_ready,
        input  in_ready, w_valid, w_word, w_index, w_last, busy
    );

    // The schedule expander itself.
    modport slave (
        input  in_valid, in_word, w_ready,
        output in_ready, w_valid, w_word, w_index, w_last, busy
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander. Loads one 512-bit block as 16 words,
// then emits W[0..63] one word per handshake using a 16-entry sliding
// window: W[t+16] is built from the window while W[t] is being offered.
module sha256_msg_schedule #(
    parameter int WORD_W = 32,   // SHA-256 word width; only 32 is meaningful
    parameter int ROUNDS = 64    // schedule words emitted per block
) (
    input  logic                   clk,
    input  logic                   rst,
    sha256_msg_schedule_if.slave   bus
);
    localparam int IDX_W = $clog2(ROUNDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(ROUNDS - 2);
    localparam logic [3:0] LAST_LOAD = 4'd15;

    typedef enum logic {
        ST_LOAD,
        ST_EMIT
    } state_t;

    // SHA-256 small sigma functions (rotations are fixed for 32-bit words).
    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    state_t                  r_state;
    logic [3:0]              r_load_cnt;
    logic [IDX_W-1:0]        r_emit_cnt;
    logic [15:0][WORD_W-1:0] r_win;       // r_win[i] holds W[emit_cnt+i] while emitting
    logic                    r_in_ready;
    logic                    r_w_valid;
    logic                    r_w_last;
    logic                    r_busy;

    logic                    w_load_fire;
    logic                    w_emit_fire;
    logic [WORD_W-1:0]       w_new_word;
    logic [15:0][WORD_W-1:0] w_win_next;

    // In LOAD the expander is always ready, so a valid word is a handshake.
    assign w_load_fire = (r_state == ST_LOAD) && bus.in_valid;
    assign w_emit_fire = (r_state == ST_EMIT) && bus.w_ready;

    // Next schedule word W[t+16] from the current window, mod 2^32.
    assign w_new_word = small_sigma1(r_win[14]) + r_win[9]
                      + small_sigma0(r_win[1]) + r_win[0];

    // Per-entry next value: capture a loaded word, shift on accept, else hold.
    for (genvar gi = 0; gi < 16; gi++) begin : g_win
        logic [WORD_W-1:0] w_shift_in;
        if (gi == 15) begin : g_tail
            assign w_shift_in = w_new_word;
        end else begin : g_body
            assign w_shift_in = r_win[gi+1];
        end

        assign w_win_next[gi] = (w_load_fire && (r_load_cnt == 4'(gi))) ? bus.in_word :
                                w_emit_fire                              ? w_shift_in  :
                                                                           r_win[gi];
    end

    // Window storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= '0;
        end else begin
            r_win <= w_win_next;
        end
    end

    // Load/emit sequencing with registered handshake and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_LOAD;
            r_load_cnt <= '0;
            r_emit_cnt <= '0;
            r_in_ready <= 1'b1;
            r_w_valid  <= 1'b0;
            r_w_last   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_load_fire) begin
                        r_busy <= 1'b1;
                        if (r_load_cnt == LAST_LOAD) begin
                            r_load_cnt <= '0;
                            r_state    <= ST_EMIT;
                            r_in_ready <= 1'b0;
                            r_w_valid  <= 1'b1;
                            r_w_last   <= (ROUNDS == 1);
                        end else begin
                            r_load_cnt <= r_load_cnt + 4'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_emit_fire) begin
                        if (r_emit_cnt == LAST_IDX) begin
                            r_emit_cnt <= '0;
                            r_state    <= ST_LOAD;
                            r_in_ready <= 1'b1;
                            r_w_valid  <= 1'b0;
                            r_w_last   <= 1'b0;
                            r_busy     <= 1'b0;
                        end else begin
                            r_emit_cnt <= r_emit_cnt + 1'b1;
                            r_w_last   <= (r_emit_cnt == PRE_LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    // All outputs come straight from registers.
    assign bus.in_ready = r_in_ready;
    assign bus.w_valid  = r_w_valid;
    assign bus.w_word   = r_win[0];
    assign bus.w_index  = r_emit_cnt;
    assign bus.w_last   = r_w_last;
    assign bus.busy     = r_busy;

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- Message-schedule expander for the SHA-256 hashing datapath.
- Accepts one 512-bit block as 16 sequential 32-bit words and emits the 64-entry schedule W[0..63], one word per handshake.
- Feeds the round/compression stage, where W[t] is summed with the choose-function result, K[t] and the state words to form T1.
- Iterative, 16-word sliding window: one adder tree, no 64-word storage.

Parameters:
- WORD_W, 32, word width; fixed by SHA-256, any other value unsupported.
- ROUNDS, 64, number of schedule words emitted per block.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_word valid
- in_ready  output  1  block accepting input words (LOAD state)
- in_word  input  32  message word; first word = most-significant 32 bits of block
- w_valid  output  1  w_word valid (EMIT state)
- w_ready  input  1  downstream accepts w_word
- w_word  output  32  schedule word W[w_index]
- w_index  output  6  round index t, 0..63
- w_last  output  1  high while w_index==63 and w_valid
- busy  output  1  high when not in LOAD with load count 0

Behaviour:
- Reset state:
  - state=LOAD, load_cnt=0, emit_cnt=0, window win[0..15]=0.
  - Outputs: in_ready=1, w_valid=0, w_word=0, w_index=0, w_last=0, busy=0.
- Functions, all arithmetic mod 2^32 with carries discarded:
  - ROTRn = rotate right by n; SHRn = logical shift right by n.
  - s0(x)=ROTR7^ROTR18^SHR3.
  - s1(x)=ROTR17^ROTR19^SHR10.
- LOAD state:
  - in_ready=1, w_valid=0.
  - On in_valid&&in_ready: win[load_cnt]<=in_word, load_cnt++.
  - in_valid low: no change; gaps of any length allowed.
  - Acceptance of the 16th word (load_cnt==15): load_cnt<=0, state<=EMIT.
- EMIT state:
  - in_ready=0; in_valid is ignored and no words are captured.
  - w_valid=1, w_word=win[0], w_index=emit_cnt.
  - Invariant: win[i] holds W[emit_cnt+i].
  - On w_valid&&w_ready:
    - Shift window: win[i]<=win[i+1] for i=0..14.
    - win[15]<=s1(win[14])+win[9]+s0(win[1])+win[0], i.e. W[t+16].
    - emit_cnt++.
  - w_ready low: all outputs and window held stable, no change until accepted.
  - Handshake at emit_cnt==63: emit_cnt<=0, state<=LOAD, window contents don't-care.
- Latency:
  - w_valid rises the cycle after the 16th input word is accepted; W[0] is then on w_word.
  - With w_ready held high, W[t] is presented t+1 cycles after the last load handshake.
  - Full block = 16 load cycles + 64 emit cycles minimum.
  - No input/output overlap: the next block's first word is accepted at the earliest in the cycle after the W[63] handshake.
- Outputs w_word/w_index/w_last are driven directly from registers; there is no combinational path from in_* or w_ready to any output.
- Reset mid-LOAD or mid-EMIT:
  - Partial block discarded, all state returns to reset values the next cycle.
  - rst has priority over any simultaneous handshake.
- W[0..15] are emitted exactly as loaded, in load order.

Test Plan:
- "abc" padded block (word0=0x61626380, words1..14=0, word15=0x00000018), w_ready=1 -> W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000. All 64 words match the software model; w_last only on index 63; in_ready returns to 1 the cycle after.
- All-ones block (16×0xFFFFFFFF) -> W[16]=0x203FFFFC, which checks mod-2^32 wrap-around; W[17..63] match the model.
- Backpressure: random w_ready (~50%) and random in_valid gaps on the "abc" block -> w_word/w_index stable while w_ready=0, no word skipped or duplicated, sequence identical to the unstalled run.
- Back-to-back: two different blocks, in_valid held high throughout -> exactly 16 words taken per block, in_ready=0 for all 64 EMIT cycles, second block's schedule correct and uncontaminated by the first.
- Reset mid-operation:
  - Assert rst after 7 loaded words -> next cycle in_ready=1, busy=0; a fresh full block then yields correct W.
  - Assert rst at emit_cnt=30 -> w_valid=0 next cycle, w_index=0.
- rst asserted in the same cycle as the 16th load handshake -> state stays LOAD, w_valid never rises.
